// File: rtl/imem_loader.sv
// Boot loader: byte stream (big-endian word-count header, then big-endian words) -> imem writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR-of-data-bytes checksum byte.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_wdata_o,
    output logic        cpu_reset_o,
    output logic        done_o,
    output logic        error_o
);
    localparam int LEN_BYTES = LEN_W / 8;
    localparam int CNT_W     = (LEN_BYTES > 4) ? $clog2(LEN_BYTES) : 2;
    localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_BYTES - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(3);
    localparam logic [LEN_W:0]   MAX_WORDS = (LEN_W + 1)'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
    localparam state_t S_TAIL = S_CSUM;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE, S_ERR} state_t;
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, len_shift;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W:0]  word_idx_q, word_idx_d;
    logic [31:0]      asm_q, asm_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             xfer;
    logic             last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       xor_q, xor_d;

    assign byte_ready_o = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
`else
    assign byte_ready_o = (state_q == S_LEN) || (state_q == S_DATA);
`endif

    assign xfer      = byte_valid_i && byte_ready_o;
    assign len_shift = (len_q << 8) | LEN_W'(byte_data_i);
    assign last_word = (LEN_W'(word_idx_q) + LEN_W'(1)) == len_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        word_idx_d  = word_idx_q;
        asm_d       = asm_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d       = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d    = S_LEN;
                    len_d      = '0;
                    cnt_d      = '0;
                    word_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d      = '0;
`endif
                end
            end
            S_LEN: begin
                if (xfer) begin
                    len_d = len_shift;
                    if (cnt_q == LEN_LAST) begin
                        cnt_d = '0;
                        if (len_shift == '0) begin
                            state_d = S_TAIL;
                        end else if ({1'b0, len_shift} > MAX_WORDS) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    asm_d = {asm_q[23:0], byte_data_i};
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ byte_data_i;
`endif
                    if (cnt_q == WORD_LAST) begin
                        // Word complete: register the write so it strobes next cycle.
                        cnt_d      = '0;
                        we_d       = 1'b1;
                        addr_d     = 32'(word_idx_q[ADDR_W-1:0]) << 2;
                        wdata_d    = asm_d;
                        word_idx_d = word_idx_q + (ADDR_W + 1)'(1);
                        if (last_word) begin
                            state_d = S_TAIL;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    state_d = (byte_data_i == xor_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // Release the core only once DONE has been held for a full cycle, i.e. after the final write.
        cpu_reset_d = !((state_q == S_DONE) && (state_d == S_DONE));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            word_idx_q  <= '0;
            asm_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cpu_reset_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            word_idx_q  <= word_idx_d;
            asm_q       <= asm_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cpu_reset_q <= cpu_reset_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign cpu_reset_o  = cpu_reset_q;
    assign done_o       = (state_q == S_DONE);
    assign error_o      = (state_q == S_ERR);

endmodule
